// File: rtl/adaptor_types.sv
// Shared types and constants for the cache-line to memory-burst adaptor.
package adaptor_types;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } adaptor_state_t;

  // 256-bit line moved as 64-bit beats; line addresses are 32-byte aligned.
  localparam int BEATS       = 4;
  localparam int OFFSET_BITS = 5;

endpackage

// File: rtl/cacheline_adaptor.sv
// Moves 256-bit cache lines to/from main memory as four 64-bit beats,
// answering the cache with a single-cycle resp_o once the burst completes.
module cacheline_adaptor
  import adaptor_types::*;
#(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  output logic               resp_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  output logic [BURST_W-1:0] burst_o,
  input  logic [BURST_W-1:0] burst_i,
  input  logic               resp_i
);

  adaptor_state_t state, state_n;
  logic [1:0]        cnt;
  logic [LINE_W-1:0] line_buf;
  logic              last_beat;

  assign last_beat = resp_i && (cnt == 2'(BEATS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      address_o <= '0;
      line_o    <= '0;
      line_buf  <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (read_i || write_i) begin
            address_o <= {address_i[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            cnt       <= '0;
            // Read wins a simultaneous request, so only a pure write loads the buffer.
            if (!read_i) line_buf <= line_i;
          end
        end
        READ: begin
          if (resp_i) begin
            line_o[cnt*BURST_W +: BURST_W] <= burst_i;
            cnt <= cnt + 2'd1;
          end
        end
        WRITE: begin
          if (resp_i) cnt <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;
    burst_o = '0;
    case (state)
      IDLE: begin
        if (read_i)       state_n = READ;
        else if (write_i) state_n = WRITE;
      end
      READ: begin
        read_o = 1'b1;
        if (last_beat) state_n = DONE;
      end
      WRITE: begin
        write_o = 1'b1;
        burst_o = line_buf[cnt*BURST_W +: BURST_W];
        if (last_beat) state_n = DONE;
      end
      DONE: begin
        // A request still held here is not restarted: accepts happen only in IDLE.
        resp_o  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
